data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 107 ++++++++++
 tb/tb_data_sram_resp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Single-port word SRAM with a fixed-latency req/addr_ok/data_ok response handshake.
// Optional DSRAM_RANDOM_DELAY_EN adds LFSR-driven extra latency (0..3 cycles) per request.
module data_sram_resp #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic [2:0]        cnt_start;
  logic              data_ok_reg;
  logic [31:0]       hold_reg;
  logic [1:0]        extra;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              unused_addr;

  logic [31:0] mem [0:2**ADDR_W-1];

  // Byte offset and bits above the array size are dropped, so addresses alias.
  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign accept      = req && (state_reg == IDLE);
  assign cnt_start   = LAT_M1 + {1'b0, extra};

`ifdef DSRAM_RANDOM_DELAY_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_reg <= 8'hA5;
    end else if (accept) begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign extra = lfsr_reg[1:0];
`else
  assign extra = 2'b00;
`endif

  // Memory contents survive reset; write lands at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      data_ok_reg <= 1'b0;
      hold_reg    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          data_ok_reg <= 1'b0;
          if (req) begin
            state_reg   <= WAIT;
            cnt_reg     <= cnt_start;
            data_ok_reg <= (cnt_start == 3'd0);
            // Old word is captured even on a write (read-before-write).
            hold_reg    <= mem[idx];
          end
        end
        WAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg     <= cnt_reg - 3'd1;
            data_ok_reg <= (cnt_reg == 3'd1);
          end else begin
            state_reg   <= IDLE;
            data_ok_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          data_ok_reg <= 1'b0;
        end
      endcase
    end
  end

  assign addr_ok = (state_reg == IDLE);
  assign data_ok = data_ok_reg;
  assign rdata   = hold_reg;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed scoreboard bench for data_sram_resp; define DSRAM_RANDOM_DELAY_EN to exercise
// the LFSR latency build (LAT=1 there).
module tb_data_sram_resp;

  localparam int ADDR_W = 10;
`ifdef DSRAM_RANDOM_DELAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  typedef struct {
    int          lat;
    logic [31:0] rd;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [0:1023];
  bit          vld [0:1023];
  logic [7:0]  lfsr_m = 8'hA5;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Extra latency for the next accept; steps the reference LFSR (x^8+x^6+x^5+x^4).
  function automatic int next_extra();
`ifdef DSRAM_RANDOM_DELAY_EN
    int e;
    e = int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    return e;
`else
    return 0;
`endif
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int i;
    i = int'(a[11:2]);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) mm[i][8*b +: 8] = d[8*b +: 8];
    end
    if (s == 4'hF) vld[i] = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the response pulse.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit hold);
    exp_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    check("idle_addr_ok", 32'(addr_ok), 32'd1);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    e.lat = LAT + next_extra();
    e.rd  = mm[int'(a[11:2])];
    e.chk = vld[int'(a[11:2])];
    sb.push_back(e);
    if (w) model_write(a, s, d);
    @(posedge clk);
    #1;
    if (!hold) begin req = 1'b0; wr = 1'b0; end
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("wait_addr_ok", 32'(addr_ok), 32'd0);
      if (data_ok) begin seen = 1'b1; break; end
      if (hold) begin
        wr = 1'b1; addr = 32'h20; wstrb = 4'hF; wdata = $urandom;
      end
    end
    req = 1'b0; wr = 1'b0;
    check("data_ok_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check("latency", 32'(n), 32'(e.lat));
      if (e.chk) check("rdata", rdata, e.rd);
    end
    @(negedge clk);
    check("pulse_end", 32'(data_ok), 32'd0);
    check("back_idle", 32'(addr_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok), 32'd1);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    resetn = 1'b1;

    // First edge after reset release accepts; full write then readback.
    do_req(1'b1, 32'h10, 4'hF, 32'h12345678, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    check("full_word", rdata, 32'h12345678);

    // Single-lane merge.
    do_req(1'b1, 32'h10, 4'b0100, 32'h00AB0000, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    check("lane_merge", rdata, 32'h12AB5678);

    // Aliasing above the array and in the byte offset.
    do_req(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
    check("alias_high", rdata, 32'hCAFEF00D);
    do_req(1'b0, 32'h3, 4'h0, 32'h0, 1'b0);
    check("alias_low", rdata, 32'hCAFEF00D);

    // Requests presented during WAIT must be ignored.
    do_req(1'b1, 32'h20, 4'hF, 32'h0BADBEEF, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    check("ignored_wait_write", rdata, 32'h0BADBEEF);

    // Zero-strobe write still responds, memory unchanged.
    do_req(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    check("wstrb_zero", rdata, 32'h12AB5678);

    // Reset mid-transaction: aborts response, keeps the write.
    check("abort_idle", 32'(addr_ok), 32'd1);
    req = 1'b1; wr = 1'b1; addr = 32'h40; wstrb = 4'hF; wdata = 32'h5A5AA5A5;
    void'(next_extra());
    model_write(32'h40, 4'hF, 32'h5A5AA5A5);
    @(posedge clk);
    #1;
    req = 1'b0; wr = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check("abort_addr_ok", 32'(addr_ok), 32'd1);
    check("abort_data_ok", 32'(data_ok), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    lfsr_m = 8'hA5;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(data_ok), 32'd0);
    end
    do_req(1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    check("write_persists", rdata, 32'h5A5AA5A5);

`ifdef DSRAM_RANDOM_DELAY_EN
    // Back-to-back reads; latency follows the LFSR reference sequence.
    for (int k = 0; k < 8; k++) begin
      do_req(1'b0, 32'(k * 4), 4'h0, 32'h0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
